slow_clock_monitor: RTL and testbench
=====================================

# slow_clock_monitor

Fast-clock-domain receiver for the divided slow clock that paces the processor. Synchronizes the incoming slow clock, turns each of its rising edges into a single-cycle `step` enable for logic running on `clk`, and measures the slow period in `clk` cycles. Flags a stall when no edge arrives within a timeout. Honours the processor `halt` line by suppressing steps without disturbing measurement.

## Interface
- `WIDTH`, 32: width of period counter and `period` output
- `TIMEOUT`, 10000000: `clk` cycles without a detected rising edge before `stalled` asserts; must be ≥ 2 and < 2^WIDTH
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `slowClk`  in  1  divided clock from the frequency divider; asynchronous to this block's sampling
- `halt`  in  1  processor halt; suppresses `step` and freezes `edgeCount`
- `step`  out  1  one-cycle pulse per detected rising edge of `slowClk`
- `period`  out  WIDTH  `clk` cycles between the last two consecutive detected rising edges
- `periodValid`  out  1  `period` holds a valid measurement
- `stalled`  out  1  no rising edge seen for `TIMEOUT` cycles
- `edgeCount`  out  16  count of issued `step` pulses, wraps modulo 2^16

## Operation
- Input path: two-flop synchronizer `s1`→`s2`, then history flop `s3`; `rise = s2 & ~s3`. All reset to 0.
- Cycle counter `cnt` (WIDTH bits) saturates at all-ones and never wraps.
- On a cycle with `rise`, `cnt <= 1`; otherwise `cnt <= cnt + 1`.
- FSM states: WAIT_FIRST (reset state), MEASURE, STALLED.
- WAIT_FIRST:
  - On `rise`: go to MEASURE; `period` and `periodValid` are unchanged.
  - Else if `cnt == TIMEOUT`: go to STALLED.
- MEASURE:
  - On `rise`: `period <= cnt`, `periodValid <= 1`; stay in MEASURE.
  - Else if `cnt == TIMEOUT`: go to STALLED, `stalled <= 1`, `periodValid <= 0`.
- STALLED:
  - On `rise`: `stalled <= 0`; go to MEASURE.
  - `period` is not updated from the stalled interval, and `periodValid` stays 0 until the next full interval.
- Entering STALLED from WAIT_FIRST also sets `stalled <= 1`.
- `step <= rise & ~halt`, registered. `edgeCount` increments by 1 on each cycle in which `step` is set. `halt` does not affect `cnt`, the FSM, `period` or `stalled`.
- A `rise` and `cnt == TIMEOUT` in the same cycle: the rise wins; no stall is flagged.
- `slowClk` high pulses shorter than one `clk` period may be missed; this is allowed. A pulse spanning at least two `clk` rising edges is always detected exactly once.

## Timing
- Reset values: `step` 0, `period` 0, `periodValid` 0, `stalled` 0, `edgeCount` 0, `cnt` 0, state WAIT_FIRST.
- Reset is asynchronous. Asserting it mid-measurement returns the block to WAIT_FIRST immediately. The first edge after reset release is never used as a period endpoint.
- Latency: `slowClk` is sampled high at `clk` edge k. `s1` goes high at k, `s2` at k+1, and `rise` is true during the cycle after k+1. `step` and `period` update at edge k+2 and are visible in the cycle after k+2.
- `step` is high for exactly one cycle per detected edge. Two steps are never adjacent, because a rise requires `s3 = 0`.
- For a periodic `slowClk` of P `clk` cycles (P ≥ 4), `period == P` after the second detected rise. Jitter of ±1 from synchronizer sampling is allowed only when `slowClk` is truly asynchronous.
- `stalled` asserts in the cycle after `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after the last rise.

## Test plan
- Reset, then `slowClk` square wave with period 10 for 5 periods:
  - First `step` appears 3 cycles after the first sampled high.
  - `periodValid` rises together with the second `step`, with `period = 10`.
  - `edgeCount = 5` at the end.
- Same stimulus with `halt = 1` during the 3rd and 4th edges: no `step` for those edges, `edgeCount = 3`, `period` still updates to 10.
- `TIMEOUT = 50`; after two edges, hold `slowClk` low:
  - `stalled = 1` and `periodValid = 0` exactly 50 cycles after the last `rise`.
  - On the next edge: `stalled = 0`, `period` unchanged, `periodValid = 0`.
  - On the following edge: `periodValid = 1`.
- `TIMEOUT = 20` with `slowClk` period 20: rise coincides with `cnt == TIMEOUT`; `stalled` never asserts and `period = 20`.
- Assert `reset` for 1 cycle mid-measurement (`cnt = 7`, `periodValid = 1`): all outputs read 0 immediately. The next two edges give `periodValid` only on the second.
- Run 65537 edges at period 4: `edgeCount` wraps to 1.

Source files
------------

// File: rtl/slow_clock_monitor.sv
// rtl/slow_clock_monitor.sv - slow clock receiver: edge-to-step, period measurement, stall detection
module slow_clock_monitor #(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slowClk,
  input  logic             halt,
  output logic             step,
  output logic [WIDTH-1:0] period,
  output logic             periodValid,
  output logic             stalled,
  output logic [15:0]      edgeCount
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STALLED} state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] period_next;
  logic             valid_next;
  logic             stalled_next;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      state       <= WAIT_FIRST;
      period      <= '0;
      periodValid <= 1'b0;
      stalled     <= 1'b0;
      step        <= 1'b0;
      edgeCount   <= 16'd0;
    end else begin
      s1          <= slowClk;
      s2          <= s1;
      s3          <= s2;
      cnt         <= cnt_next;
      state       <= state_next;
      period      <= period_next;
      periodValid <= valid_next;
      stalled     <= stalled_next;
      step        <= rise & ~halt;
      if (step) edgeCount <= edgeCount + 16'd1;
    end
  end

  always_comb begin
    cnt_next     = cnt;
    state_next   = state;
    period_next  = period;
    valid_next   = periodValid;
    stalled_next = stalled;

    // Saturate so a very long stall can never alias back onto TIMEOUT.
    if (rise)            cnt_next = WIDTH'(1);
    else if (cnt != '1)  cnt_next = cnt + 1'b1;

    // A rise always takes priority over a coincident timeout.
    case (state)
      WAIT_FIRST: begin
        if (rise) begin
          state_next = MEASURE;
        end else if (cnt == TIMEOUT_W) begin
          state_next   = STALLED;
          stalled_next = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_next = cnt;
          valid_next  = 1'b1;
        end else if (cnt == TIMEOUT_W) begin
          state_next   = STALLED;
          stalled_next = 1'b1;
          valid_next   = 1'b0;
        end
      end
      STALLED: begin
        if (rise) begin
          state_next   = MEASURE;
          stalled_next = 1'b0;
        end
      end
      default: state_next = WAIT_FIRST;
    endcase
  end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb/tb_slow_clock_monitor.sv - self-checking bench for slow_clock_monitor
module tb_slow_clock_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slowClk = 1'b0;
  logic        halt = 1'b0;
  logic        step, periodValid, stalled;
  logic [31:0] period;
  logic [15:0] edgeCount;
  logic        step20, periodValid20, stalled20;
  logic [31:0] period20;
  logic [15:0] edgeCount20;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slow_clock_monitor #(.WIDTH(32), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .slowClk(slowClk), .halt(halt),
    .step(step), .period(period), .periodValid(periodValid),
    .stalled(stalled), .edgeCount(edgeCount)
  );

  slow_clock_monitor #(.WIDTH(32), .TIMEOUT(20)) dut20 (
    .clk(clk), .reset(reset), .slowClk(slowClk), .halt(halt),
    .step(step20), .period(period20), .periodValid(periodValid20),
    .stalled(stalled20), .edgeCount(edgeCount20)
  );

  typedef struct {
    int p;
    int n;
    int hlo;
    int hhi;
    int exp_cnt;
    int exp_period;
    int exp_pv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    slowClk = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_period", period, 0);
    chk("rst_pv", {31'd0, periodValid}, 0);
    chk("rst_stalled", {31'd0, stalled}, 0);
    chk("rst_edgecount", {16'd0, edgeCount}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Square wave of n periods of p cycles (high first half); halt covers edges hlo..hhi.
  task automatic run_wave(input int p, input int n, input int hlo, input int hhi, output int steps);
    logic prev;
    steps = 0;
    prev = 1'b0;
    for (int e = 0; e < n + 1; e++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (step) steps++;
        if (step && prev) chk("step_adjacent", 1, 0);
        prev = step;
        slowClk = (e < n) && (c < p / 2);
        halt = (e < n) && (e >= hlo) && (e <= hhi);
      end
    end
  endtask

  initial begin
    int steps;
    vecs[0] = '{p: 10, n: 5, hlo: 1, hhi: 0, exp_cnt: 5, exp_period: 10, exp_pv: 1};
    vecs[1] = '{p: 10, n: 5, hlo: 2, hhi: 3, exp_cnt: 3, exp_period: 10, exp_pv: 1};
    vecs[2] = '{p: 6,  n: 3, hlo: 1, hhi: 0, exp_cnt: 3, exp_period: 6,  exp_pv: 1};
    vecs[3] = '{p: 4,  n: 6, hlo: 1, hhi: 0, exp_cnt: 6, exp_period: 4,  exp_pv: 1};
    vecs[4] = '{p: 7,  n: 1, hlo: 1, hhi: 0, exp_cnt: 1, exp_period: 0,  exp_pv: 0};
    vecs[5] = '{p: 13, n: 4, hlo: 0, hhi: 3, exp_cnt: 0, exp_period: 13, exp_pv: 1};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_wave(vecs[i].p, vecs[i].n, vecs[i].hlo, vecs[i].hhi, steps);
      chk($sformatf("v%0d_steps", i), steps, vecs[i].exp_cnt);
      chk($sformatf("v%0d_edgecount", i), {16'd0, edgeCount}, vecs[i].exp_cnt);
      chk($sformatf("v%0d_period", i), period, vecs[i].exp_period);
      chk($sformatf("v%0d_pv", i), {31'd0, periodValid}, vecs[i].exp_pv);
      chk($sformatf("v%0d_stalled", i), {31'd0, stalled}, 0);
    end

    // Latency: first step 3 cycles after first sampled high; pv rises with second step.
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("lat_step", {31'd0, step}, (c == 3 || c == 13) ? 1 : 0);
        chk("lat_pv", {31'd0, periodValid}, (c >= 13) ? 1 : 0);
        chk("lat_period", period, (c >= 13) ? 10 : 0);
      end
      slowClk = (c % 10) < 5;
    end

    // Stall: TIMEOUT 50 after two edges, then recovery over two further edges.
    do_reset();
    for (int c = 0; c <= 85; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("stall_stalled", {31'd0, stalled}, (c >= 63 && c < 73) ? 1 : 0);
        chk("stall_pv", {31'd0, periodValid}, ((c >= 13 && c < 63) || c >= 83) ? 1 : 0);
        chk("stall_period", period, (c >= 13) ? 10 : 0);
      end
      slowClk = (c < 5) || (c >= 10 && c < 15) || (c >= 70 && c < 75) || (c >= 80 && c < 85);
    end

    // Rise coincides with cnt == TIMEOUT on the TIMEOUT=20 instance.
    do_reset();
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (c > 0) chk("coinc_stalled", {31'd0, stalled20}, 0);
      slowClk = (c < 80) && ((c % 20) < 10);
    end
    chk("coinc_period", period20, 20);
    chk("coinc_pv", {31'd0, periodValid20}, 1);

    // Asynchronous reset mid-measurement (cnt = 7, periodValid = 1).
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 13) begin
        chk("mid_pre_pv", {31'd0, periodValid}, 1);
        chk("mid_pre_period", period, 10);
      end
      if (c == 28) begin
        chk("mid_step1", {31'd0, step}, 1);
        chk("mid_pv_after1", {31'd0, periodValid}, 0);
      end
      if (c == 29) chk("mid_edgecount", {16'd0, edgeCount}, 1);
      if (c == 37) chk("mid_pv_before2", {31'd0, periodValid}, 0);
      if (c == 38) begin
        chk("mid_pv_after2", {31'd0, periodValid}, 1);
        chk("mid_period_after2", period, 10);
      end
      slowClk = (c < 5) || (c >= 10 && c < 15) || (c >= 25 && c < 30) || (c >= 35 && c < 40);
      if (c == 19) begin
        reset = 1'b1;
        #1;
        chk("mid_rst_step", {31'd0, step}, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_pv", {31'd0, periodValid}, 0);
        chk("mid_rst_stalled", {31'd0, stalled}, 0);
        chk("mid_rst_edgecount", {16'd0, edgeCount}, 0);
      end
      if (c == 20) reset = 1'b0;
    end

    // edgeCount wrap: preset near the top, then five edges at period 4.
    do_reset();
    @(negedge clk);
    force dut.edgeCount = 16'hFFFC;
    @(negedge clk);
    @(negedge clk);
    release dut.edgeCount;
    run_wave(4, 5, 1, 0, steps);
    chk("wrap_steps", steps, 5);
    chk("wrap_edgecount", {16'd0, edgeCount}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
